// File: rtl/multdiv_wb_ctrl_if.sv
// rtl/multdiv_wb_ctrl_if.sv - decode/writeback-side bus of the mult/div writeback controller
// master: pipeline side (decode, mult/div unit, writeback); slave: controller.
interface multdiv_wb_ctrl_if #(
  parameter int ADDR_W = 5
) ();
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic              md_start;
  logic              md_ready;
  logic              md_exception;
  logic [ADDR_W-1:0] src_a_addr;
  logic [ADDR_W-1:0] src_b_addr;
  logic              hazard_stall;
  logic              wb_pipe_valid;
  logic [ADDR_W-1:0] wb_pipe_rd;
  logic              wb_pipe_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic              exc_wb;
  logic              busy;
  logic              timeout;

  modport master (
    output issue_valid, issue_rd, md_ready, md_exception,
           src_a_addr, src_b_addr, wb_pipe_valid, wb_pipe_rd,
    input  issue_ready, md_start, hazard_stall, wb_pipe_stall,
           rf_we, rf_waddr, exc_wb, busy, timeout
  );

  modport slave (
    input  issue_valid, issue_rd, md_ready, md_exception,
           src_a_addr, src_b_addr, wb_pipe_valid, wb_pipe_rd,
    output issue_ready, md_start, hazard_stall, wb_pipe_stall,
           rf_we, rf_waddr, exc_wb, busy, timeout
  );
endinterface

// File: rtl/multdiv_wb_ctrl.sv
// rtl/multdiv_wb_ctrl.sv - mult/div issue, hazard stall and register-file writeback arbitration
// Optional BUSY watchdog compiled in with MD_TIMEOUT_EN.
module multdiv_wb_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int EXC_REG = 30,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  multdiv_wb_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(EXC_REG);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_held_rd;
  logic              r_held_exc;
  logic              r_timeout;

  logic              w_issue;
  logic              w_done;
  logic              w_tmo_hit;
  logic              w_src_hit_rd;
  logic              w_src_hit_exc;

  logic              w_issue_ready;
  logic              w_md_start;
  logic              w_hazard_stall;
  logic              w_wb_pipe_stall;
  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_waddr;
  logic              w_exc_wb;
  logic              w_busy;

  assign w_issue = bus.issue_valid && (r_state == S_IDLE);
  assign w_done  = bus.md_ready && (r_state == S_BUSY);

`ifdef MD_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A result arriving on the last allowed cycle wins over the watchdog.
  assign w_tmo_hit = (r_state == S_BUSY) && !bus.md_ready &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(CNT_W), 32'(TIMEOUT)};
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_held_rd  <= '0;
      r_held_exc <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_held_rd <= bus.issue_rd;
      end
      if (w_done) begin
        r_held_exc <= bus.md_exception;
      end else if (w_tmo_hit) begin
        r_held_exc <= 1'b1;
      end
      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_src_hit_rd  = (r_held_rd != '0) &&
                         ((bus.src_a_addr == r_held_rd) || (bus.src_b_addr == r_held_rd));
  // While BUSY the outcome is unknown, so readers of the exception register must wait too.
  assign w_src_hit_exc = ((bus.src_a_addr == EXC_ADDR) || (bus.src_b_addr == EXC_ADDR)) &&
                         (r_held_exc || (r_state == S_BUSY));

  always_comb begin
    w_next          = r_state;
    w_issue_ready   = 1'b0;
    w_md_start      = 1'b0;
    w_busy          = 1'b1;
    w_rf_we         = 1'b0;
    w_rf_waddr      = '0;
    w_exc_wb        = 1'b0;
    w_wb_pipe_stall = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_issue_ready = 1'b1;
        w_busy        = 1'b0;
        w_md_start    = bus.issue_valid;
        if (bus.issue_valid) begin
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_done || w_tmo_hit) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_rf_we         = r_held_exc || (r_held_rd != '0);
        w_rf_waddr      = r_held_exc ? EXC_ADDR : r_held_rd;
        w_exc_wb        = r_held_exc;
        w_wb_pipe_stall = bus.wb_pipe_valid && (bus.wb_pipe_rd != '0);
        w_next          = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_hazard_stall = (bus.issue_valid && !w_issue_ready) ||
                          ((r_state != S_IDLE) && (w_src_hit_rd || w_src_hit_exc));

  assign bus.issue_ready   = w_issue_ready;
  assign bus.md_start      = w_md_start;
  assign bus.hazard_stall  = w_hazard_stall;
  assign bus.wb_pipe_stall = w_wb_pipe_stall;
  assign bus.rf_we         = w_rf_we;
  assign bus.rf_waddr      = w_rf_waddr;
  assign bus.exc_wb        = w_exc_wb;
  assign bus.busy          = w_busy;
  assign bus.timeout       = r_timeout;

endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// tb/tb_multdiv_wb_ctrl.sv - randomized self-checking bench for multdiv_wb_ctrl
// Honors MD_TIMEOUT_EN the same way the design does.
module tb_multdiv_wb_ctrl;

  localparam int TIMEOUT = 40;
  localparam int EXC_REG = 30;
`ifdef MD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  multdiv_wb_ctrl_if #(.ADDR_W(5)) bus ();

  multdiv_wb_ctrl #(
    .ADDR_W (5),
    .EXC_REG(EXC_REG),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (6)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Reference: an op is either outstanding (waiting for its result) or retiring this cycle.
  bit m_waiting;
  bit m_writing;
  bit m_exc;
  bit m_tmo;
  int m_rd;
  int m_cycles;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_waiting = 0;
    m_writing = 0;
    m_exc     = 0;
    m_tmo     = 0;
    m_rd      = 0;
    m_cycles  = 0;
  endtask

  task automatic drive(input bit iv, input int ird, input bit mr, input bit me,
                       input int a, input int b, input bit pv, input int prd);
    bus.issue_valid   = iv;
    bus.issue_rd      = 5'(ird);
    bus.md_ready      = mr;
    bus.md_exception  = me;
    bus.src_a_addr    = 5'(a);
    bus.src_b_addr    = 5'(b);
    bus.wb_pipe_valid = pv;
    bus.wb_pipe_rd    = 5'(prd);
  endtask

  task automatic cyc(input string tag, input bit iv, input int ird, input bit mr, input bit me,
                     input int a, input int b, input bit pv, input int prd);
    int e_busy, e_ready, e_hz;
    @(negedge clk);
    drive(iv, ird, mr, me, a, b, pv, prd);
    #1;
    e_busy  = (m_waiting || m_writing) ? 1 : 0;
    e_ready = 1 - e_busy;
    e_hz    = ((iv && e_ready == 0) ||
               (e_busy == 1 && m_rd != 0 && (a == m_rd || b == m_rd)) ||
               (e_busy == 1 && (a == EXC_REG || b == EXC_REG) && (m_waiting || m_exc))) ? 1 : 0;
    check({tag, ".issue_ready"}, 32'(bus.issue_ready), e_ready);
    check({tag, ".busy"}, 32'(bus.busy), e_busy);
    check({tag, ".md_start"}, 32'(bus.md_start), (iv && e_ready == 1) ? 1 : 0);
    check({tag, ".hazard_stall"}, 32'(bus.hazard_stall), e_hz);
    check({tag, ".rf_we"}, 32'(bus.rf_we), (m_writing && (m_rd != 0 || m_exc)) ? 1 : 0);
    check({tag, ".rf_waddr"}, 32'(bus.rf_waddr), m_writing ? (m_exc ? EXC_REG : m_rd) : 0);
    check({tag, ".exc_wb"}, 32'(bus.exc_wb), (m_writing && m_exc) ? 1 : 0);
    check({tag, ".wb_pipe_stall"}, 32'(bus.wb_pipe_stall), (m_writing && pv && prd != 0) ? 1 : 0);
    check({tag, ".timeout"}, 32'(bus.timeout), m_tmo ? 1 : 0);
    @(posedge clk);
    if (m_writing) begin
      m_writing = 0;
    end else if (m_waiting) begin
      m_cycles++;
      if (mr) begin
        m_exc     = me;
        m_waiting = 0;
        m_writing = 1;
      end else if (TMO_EN && m_cycles == TIMEOUT) begin
        m_exc     = 1;
        m_tmo     = 1;
        m_waiting = 0;
        m_writing = 1;
      end
    end else if (iv) begin
      m_waiting = 1;
      m_rd      = ird;
      m_cycles  = 0;
    end
  endtask

  task automatic idle(input string tag, input int n, input int a = 0, input int b = 0);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, a, b, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".issue_ready"}, 32'(bus.issue_ready), 1);
    check({tag, ".rf_we"}, 32'(bus.rf_we), 0);
    check({tag, ".timeout"}, 32'(bus.timeout), 0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int a, b, ird, pick;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("por.issue_ready", 32'(bus.issue_ready), 1);
    check("por.busy", 32'(bus.busy), 0);
    check("por.md_start", 32'(bus.md_start), 0);
    check("por.hazard_stall", 32'(bus.hazard_stall), 0);
    check("por.rf_we", 32'(bus.rf_we), 0);
    #2;
    rst_n = 1'b1;
    idle("idle0", 2);

    // Reset mid-op abandons it; a later md_ready must not produce a write.
    cyc("rb.issue", 1, 5, 0, 0, 0, 0, 0, 0);
    idle("rb.busy", 3);
    async_reset("rb.rst");
    cyc("rb.late_rdy", 0, 0, 1, 0, 0, 0, 0, 0);
    idle("rb.after", 2);

    cyc("ok.issue", 1, 7, 0, 0, 0, 0, 0, 0);
    idle("ok.busy", 16);
    cyc("ok.rdy", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("ok.wb", 0, 0, 0, 0, 0, 0, 0, 0);
    idle("ok.idle", 1);

    cyc("ex.issue", 1, 9, 0, 0, 0, 0, 0, 0);
    idle("ex.busy", 4);
    cyc("ex.rdy", 0, 0, 1, 1, 0, 0, 0, 0);
    cyc("ex.wb", 0, 0, 0, 0, 30, 0, 0, 0);
    idle("ex.idle", 1);

    cyc("hz.issue", 1, 4, 0, 0, 0, 0, 0, 0);
    cyc("hz.hit_a", 0, 0, 0, 0, 4, 0, 0, 0);
    cyc("hz.miss", 0, 0, 0, 0, 3, 0, 0, 0);
    cyc("hz.exc_busy", 0, 0, 0, 0, 0, 30, 0, 0);
    cyc("hz.reissue", 1, 8, 0, 0, 3, 0, 0, 0);
    cyc("hz.rdy", 0, 0, 1, 0, 3, 0, 0, 0);
    cyc("hz.wb", 0, 0, 0, 0, 3, 0, 0, 0);
    idle("hz.after", 2, 3, 0);

    cyc("ps.issue", 1, 3, 0, 0, 0, 0, 0, 0);
    cyc("ps.rdy", 0, 0, 1, 0, 0, 0, 1, 12);
    cyc("ps.wb12", 0, 0, 0, 0, 0, 0, 1, 12);
    cyc("ps.issue2", 1, 3, 0, 0, 0, 0, 0, 0);
    cyc("ps.rdy2", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("ps.wb0", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("r0.issue", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("r0.rdy", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("r0.wb", 0, 0, 0, 0, 0, 0, 1, 5);
    cyc("b2b.issue", 1, 11, 0, 0, 0, 0, 0, 0);
    cyc("b2b.rdy", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("b2b.wb_issue", 1, 13, 0, 0, 0, 0, 0, 0);
    cyc("b2b.issue2", 1, 13, 0, 0, 0, 0, 0, 0);
    cyc("b2b.rdy2", 0, 0, 1, 1, 0, 0, 0, 0);
    cyc("b2b.wb2", 0, 0, 0, 0, 13, 0, 0, 0);

    cyc("to.issue", 1, 6, 0, 0, 0, 0, 0, 0);
    idle("to.wait", 105, 6, 30);
    check("to.busy_at_100", 32'(bus.busy), TMO_EN ? 0 : 1);
    check("to.sticky", 32'(bus.timeout), TMO_EN ? 1 : 0);
    async_reset("to.rst");
    idle("to.after", 1);

    for (int i = 0; i < 1500; i++) begin
      pick = int'($urandom_range(0, 3));
      a    = (pick == 0) ? m_rd : (pick == 1) ? EXC_REG : int'($urandom_range(0, 31));
      b    = (pick == 2) ? m_rd : int'($urandom_range(0, 31));
      ird  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
      cyc("rnd", ($urandom_range(0, 2) == 0), ird, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), a, b, ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
